// File: rtl/pprr_pkg.sv
// Shared definitions for the round-robin bus requester: channel state
// encoding, default sizes, starvation limit and a one-hot check helper.
package pprr_pkg;

    localparam int unsigned N_DEF        = 8;
    localparam int unsigned LEN_W_DEF    = 4;
    localparam int unsigned STARVE_W     = 8;
    localparam int unsigned STARVE_LIMIT = 255;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_REQ  = 2'd1,
        CH_XFER = 2'd2
    } chan_state_e;

    // True when exactly one bit of v is set (callers zero-extend to 32 bits).
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage : pprr_pkg

// File: rtl/rr_req_chan.sv
// One requester channel: accepts a command, requests the arbiter, follows
// the bus through its burst and pulses done when the burst ends.
// Optional REQ_STARVE_CHK_EN adds a sticky starvation flag on long waits.
module rr_req_chan
    import pprr_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             cmd_vld,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             bus_free,
    input  logic             granted,
    input  logic             burst_end,
    output logic             cmd_rdy,
    output logic             req,
    output logic             done,
    output logic [LEN_W-1:0] len
`ifdef REQ_STARVE_CHK_EN
    ,
    output logic             starve
`endif
);

    chan_state_e      state_q, state_d;
    logic             rdy_q, rdy_d;
    logic             req_q, req_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] len_q;

    // Next-state and next-output decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CH_IDLE: if (cmd_vld)              state_d = CH_REQ;
            CH_REQ:  if (bus_free && granted)  state_d = CH_XFER;
            CH_XFER: if (burst_end)            state_d = CH_IDLE;
            default:                           state_d = CH_IDLE;
        endcase
        rdy_d  = (state_d == CH_IDLE);
        req_d  = (state_d == CH_REQ);
        done_d = (state_q == CH_XFER) && burst_end;
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= CH_IDLE;
            rdy_q   <= 1'b1;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            req_q   <= req_d;
            done_q  <= done_d;
        end
    end

    // Burst length captured on command accept.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            len_q <= '0;
        end else if (state_q == CH_IDLE && cmd_vld) begin
            len_q <= cmd_len;
        end
    end

    assign cmd_rdy = rdy_q;
    assign req     = req_q;
    assign done    = done_q;
    assign len     = len_q;

`ifdef REQ_STARVE_CHK_EN
    logic [STARVE_W-1:0] wait_q, wait_d;
    logic                starve_q;

    // Wait counter: runs while requesting, saturates at the limit.
    always_comb begin
        wait_d = '0;
        if (state_q == CH_REQ && !(bus_free && granted)) begin
            wait_d = (wait_q == STARVE_W'(STARVE_LIMIT)) ? wait_q
                                                         : wait_q + STARVE_W'(1);
        end
    end

    // Counter register and sticky starvation flag.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wait_q   <= '0;
            starve_q <= 1'b0;
        end else begin
            wait_q   <= wait_d;
            starve_q <= starve_q | (wait_d == STARVE_W'(STARVE_LIMIT));
        end
    end

    assign starve = starve_q;
`endif

endmodule : rr_req_chan

// File: rtl/rr_bus_requester.sv
// Requester front end for an N-way round-robin arbiter. Drives the request
// vector, takes the one-hot grant while the bus is free, locks the bus to
// the winner for len+1 beats and flags protocol errors (sticky).
// Optional REQ_STARVE_CHK_EN adds the o_starve output.
module rr_bus_requester
    import pprr_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic [N-1:0]       i_cmd_vld,
    input  logic [N*LEN_W-1:0] i_cmd_len,
    output logic [N-1:0]       o_cmd_rdy,
    output logic [N-1:0]       o_req,
    input  logic [N-1:0]       i_grant,
    input  logic               i_ag,
    output logic               o_bus_vld,
    output logic [N-1:0]       o_bus_sel,
    output logic               o_bus_last,
    output logic [N-1:0]       o_done,
    output logic               o_err
`ifdef REQ_STARVE_CHK_EN
    ,
    output logic [N-1:0]       o_starve
`endif
);

    logic [N-1:0]            owner_q, owner_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic                    vld_q, vld_d;
    logic                    last_q, last_d;
    logic                    err_q;
    logic [N-1:0][LEN_W-1:0] chan_len;
    logic [LEN_W-1:0]        owner_len;
    logic [LEN_W-1:0]        grant_len;
    logic                    bus_free;
    logic                    grant_1h;
    logic                    grant_ok;
    logic                    grant_hit;
    logic                    take;
    logic                    burst_end;
    logic                    err_set;

    // Grant qualification and protocol-error detection.
    always_comb begin
        bus_free  = ~|owner_q;
        grant_1h  = is_onehot(32'(i_grant));
        grant_ok  = i_ag && grant_1h;
        grant_hit = |(i_grant & o_req);
        take      = bus_free && grant_ok && grant_hit;
        err_set   = bus_free && ((i_ag && !grant_1h) ||
                                 (grant_ok && !grant_hit) ||
                                 (!i_ag && (|i_grant)));
    end

    // Length of the current owner and of the incoming grantee.
    always_comb begin
        owner_len = '0;
        grant_len = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (owner_q[k]) owner_len = owner_len | chan_len[k];
            if (i_grant[k]) grant_len = grant_len | chan_len[k];
        end
        burst_end = !bus_free && (cnt_q == owner_len);
    end

    // Bus ownership and beat counter next state.
    always_comb begin
        owner_d = owner_q;
        cnt_d   = cnt_q;
        last_d  = 1'b0;
        if (bus_free) begin
            if (take) begin
                owner_d = i_grant;
                cnt_d   = '0;
                last_d  = (grant_len == '0);
            end
        end else if (burst_end) begin
            owner_d = '0;
            cnt_d   = '0;
        end else begin
            cnt_d  = cnt_q + LEN_W'(1);
            last_d = (cnt_d == owner_len);
        end
        vld_d = |owner_d;
    end

    // Bus registers and sticky error flag.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            owner_q <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            err_q   <= err_q | err_set;
        end
    end

    assign o_bus_sel  = owner_q;
    assign o_bus_vld  = vld_q;
    assign o_bus_last = last_q;
    assign o_err      = err_q;

    // One requester channel per client.
    for (genvar k = 0; k < N; k++) begin : g_chan
        rr_req_chan #(
            .LEN_W (LEN_W)
        ) u_chan (
            .i_clk     (i_clk),
            .i_rstn    (i_rstn),
            .cmd_vld   (i_cmd_vld[k]),
            .cmd_len   (i_cmd_len[k*LEN_W +: LEN_W]),
            .bus_free  (bus_free),
            .granted   (grant_ok && i_grant[k]),
            .burst_end (burst_end && owner_q[k]),
            .cmd_rdy   (o_cmd_rdy[k]),
            .req       (o_req[k]),
            .done      (o_done[k]),
            .len       (chan_len[k])
`ifdef REQ_STARVE_CHK_EN
            ,
            .starve    (o_starve[k])
`endif
        );
    end

endmodule : rr_bus_requester
